// File: rtl/uart_rx_oversampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_oversampler                                           |
// | Function : 16x oversampling 8N1 UART receive front end. Recovers bytes   |
// |            with 2-of-3 majority voting per bit, flags framing errors and |
// |            overruns, and stretches the byte-valid flag so a slower       |
// |            consumer clock domain can edge-detect it.                     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_rx_oversampler #(
  parameter int DIV         = 651,
  parameter int STATUS_HOLD = 6000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] c_DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] c_HOLD     = 16'(STATUS_HOLD);

  // r_s counts ticks already elapsed in the current bit, so the tick being
  // processed is sample number r_s+1. Samples 7, 8, 9 are therefore taken
  // while r_s reads 6, 7, 8, and the bit decision is the r_s == 8 tick.
  localparam logic [3:0]  c_SMP_A    = 4'd6;
  localparam logic [3:0]  c_SMP_B    = 4'd7;
  localparam logic [3:0]  c_SMP_DEC  = 4'd8;
  localparam logic [3:0]  c_LAST_BIT = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_rx_s;
  logic        r_rx_d;
  logic [15:0] r_div;
  logic [3:0]  r_s;
  logic [3:0]  r_b;
  logic        r_v0;
  logic        r_v1;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_status;
  logic [15:0] r_hold;
  logic        r_frame_err;
  logic        r_overrun;
  logic        r_busy;

  logic        w_start;
  logic        w_tick;
  logic        w_maj;

  assign w_start = r_rx_d & ~r_rx_s;
  assign w_tick  = (r_div == c_DIV_LAST);
  // Two earlier samples plus the live sample on the decision tick
  assign w_maj   = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);

  // Bring the asynchronous pin into sysclk and keep a delayed copy for edge detection
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  // Oversample tick divider, re-phased on the start edge so the first tick lands DIV cycles later
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_div <= '0;
    end else if ((r_state == ST_IDLE) && w_start) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // Frame FSM with bit/sample counters, shift register, hold window and registered flags
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_b         <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_shift     <= '0;
      r_data      <= '0;
      r_status    <= 1'b0;
      r_hold      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Byte-valid window countdown; a good frame below reloads it
      if (r_status) begin
        if (r_hold == 16'd1) begin
          r_status <= 1'b0;
          r_hold   <= '0;
        end else begin
          r_hold <= r_hold - 16'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          // Only a 1->0 transition starts a frame; a line already low is ignored
          if (w_start) begin
            r_state <= ST_START;
            r_s     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          if (w_tick) begin
            r_s <= r_s + 4'd1;
            if (r_s == 4'd15) begin
              r_b <= r_b + 4'd1;
            end
            if (r_s == c_SMP_A) begin
              r_v0 <= r_rx_s;
            end
            if (r_s == c_SMP_B) begin
              r_v1 <= r_rx_s;
            end
            if (r_s == c_SMP_DEC) begin
              case (r_state)
                ST_START: begin
                  if (w_maj) begin
                    // Start bit did not hold low: treat as a glitch
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                  end else begin
                    r_state <= ST_DATA;
                  end
                end
                ST_DATA: begin
                  r_shift <= {w_maj, r_shift[7:1]};
                  if (r_b == c_LAST_BIT) begin
                    r_state <= ST_STOP;
                  end
                end
                ST_STOP: begin
                  if (w_maj) begin
                    r_data    <= r_shift;
                    r_status  <= 1'b1;
                    r_hold    <= c_HOLD;
                    r_overrun <= r_status;
                  end else begin
                    r_frame_err <= 1'b1;
                  end
                  // Leave at mid-stop so a back-to-back start edge is still caught
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end
                default: begin
                  r_state <= ST_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_status = r_status;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_oversampler                                        |
// | Function : Self-checking bench for uart_rx_oversampler. A timing-formula |
// |            reference model predicts every output each cycle; directed   |
// |            scenarios pin latency, hold window, glitch, noise, overrun   |
// |            and reset behaviour with literal values; random frames      |
// |            follow.                                                      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_uart_rx_oversampler;

  localparam int DIV     = 4;
  localparam int HOLD    = 700;
  localparam int BIT_CYC = 16 * DIV;
  localparam int HSIZE   = 65536;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_oversampler #(.DIV(DIV), .STATUS_HOLD(HOLD)) dut (
    .sysclk   (clk),
    .reset    (rst),
    .UART_RX  (pin),
    .rx_data  (rx_data),
    .rx_status(rx_status),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Works from absolute times: the synchronized line is the pin two cycles
  // back, ticks fall at E + k*DIV after the start edge E, tick k belongs to
  // bit k/16 at sample k%16, and bits are decided on sample 9.
  bit        pin_hist[HSIZE];
  int        last_rst      = 0;
  bit        m_active      = 0;
  int        m_E           = 0;
  bit [7:0]  m_byte        = 8'h00;
  bit [7:0]  m_data        = 8'h00;
  int        m_status_last = -1;
  bit        m_fe          = 0;
  bit        m_ov          = 0;
  bit        m_busy        = 0;
  bit        votes[3];

  function automatic bit rs_at(input int n);
    if (n <= last_rst + 2) return 1'b1;
    return pin_hist[(n - 2) % HSIZE];
  endfunction

  function automatic bit rd_at(input int n);
    if (n <= last_rst + 1) return 1'b1;
    return rs_at(n - 1);
  endfunction

  // Given inputs seen during cycle n, set the outputs expected in cycle n+1
  function automatic void model_step(input int n, input logic r);
    int t, k, b, sp;
    bit maj;
    if (r) begin
      m_data = 8'h00; m_status_last = -1; m_fe = 0; m_ov = 0;
      m_busy = 0; m_active = 0; last_rst = n;
    end else begin
      m_fe = 0;
      m_ov = 0;
      if (!m_active) begin
        if (!rs_at(n) && rd_at(n)) begin
          m_active = 1;
          m_E = n;
        end
      end else begin
        t = n - m_E;
        if (t % DIV == 0) begin
          k  = t / DIV;
          b  = k / 16;
          sp = k % 16;
          if (sp >= 7 && sp <= 9) votes[sp - 7] = rs_at(n);
          if (sp == 9) begin
            maj = (int'(votes[0]) + int'(votes[1]) + int'(votes[2])) >= 2;
            if (b == 0) begin
              if (maj) m_active = 0;
            end else if (b <= 8) begin
              m_byte[b - 1] = maj;
            end else begin
              if (maj) begin
                m_ov = (n <= m_status_last);
                m_data = m_byte;
                m_status_last = n + HOLD;
              end else begin
                m_fe = 1;
              end
              m_active = 0;
            end
          end
        end
      end
      m_busy = m_active;
    end
  endfunction

  // ---------------- event monitor state ----------------
  bit       prev_status   = 0;
  int       rise_cnt      = 0;
  int       last_rise     = -1;
  int       last_fall     = -1;
  bit [7:0] data_at_rise  = 8'h00;
  int       fe_cnt        = 0;
  int       last_fe       = -1;
  int       ov_cnt        = 0;
  int       last_ov       = -1;
  int       busy_run      = 0;
  int       last_busy_len = 0;

  // Per-cycle comparison against the model, then event bookkeeping, then model advance
  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] expv;
    act  = {rx_data, rx_status, frame_err, overrun, busy};
    expv = {m_data, (cyc <= m_status_last), m_fe, m_ov, m_busy};
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL outputs cycle %0d: got data=%h status=%b fe=%b ov=%b busy=%b, expected data=%h status=%b fe=%b ov=%b busy=%b",
               cyc, act[11:4], act[3], act[2], act[1], act[0],
               expv[11:4], expv[3], expv[2], expv[1], expv[0]);
    end
    if (rx_status && !prev_status) begin
      rise_cnt++;
      last_rise    = cyc;
      data_at_rise = rx_data;
    end
    if (!rx_status && prev_status) last_fall = cyc;
    if (frame_err) begin fe_cnt++; last_fe = cyc; end
    if (overrun) begin ov_cnt++; last_ov = cyc; end
    if (busy) begin
      busy_run++;
    end else begin
      if (busy_run > 0) last_busy_len = busy_run;
      busy_run = 0;
    end
    prev_status = rx_status;
    pin_hist[cyc % HSIZE] = pin;
    model_step(cyc, rst);
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1 pin = 1'b1; end
  endtask

  task automatic low(input int n);
    repeat (n) begin @(posedge clk); #1 pin = 1'b0; end
  endtask

  // One 8N1 frame; pin offsets [flip_at, flip_at+flip_len) are inverted,
  // and a one-cycle reset at offset rst_at aborts the frame with the line idle.
  task automatic drive_frame(input logic [7:0] d, input bit stop, input int flip_at,
                             input int flip_len, input int rst_at, output int fall_cyc);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    fall_cyc = -1;
    for (int i = 0; i < 10 * BIT_CYC; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) fall_cyc = cyc;
      if (i == rst_at) begin
        rst = 1'b1;
        pin = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      pin = bits[i / BIT_CYC] ^ ((i >= flip_at) && (i < flip_at + flip_len));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p, p2, fe0, rise0, ov0, fa, fl, ra, gap;
    bit stop;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(20);
    @(negedge clk);
    check("reset_state", int'({rx_data, rx_status, frame_err, overrun, busy}), 0);

    // Good frame: 153*4+3 = 615 cycles pin-fall to status, held 700 cycles
    drive_frame(8'hA5, 1'b1, -1, 0, -1, p);
    idle(800);
    check("a5_latency", last_rise - p, 615);
    check("a5_data", int'(data_at_rise), 'hA5);
    check("a5_hold_len", last_fall - last_rise, 700);
    check("a5_no_frame_err", fe_cnt, 0);
    check("a5_rise_count", rise_cnt, 1);

    // Framing error, then the line stays low: no new frame may start
    fe0 = fe_cnt; rise0 = rise_cnt;
    drive_frame(8'h3C, 1'b0, -1, 0, -1, p);
    low(100);
    @(negedge clk);
    check("fe_no_restart_busy", int'(busy), 0);
    check("fe_latency", last_fe - p, 615);
    check("fe_count", fe_cnt - fe0, 1);
    check("fe_data_kept", int'(rx_data), 'hA5);
    check("fe_status_low", int'(rx_status), 0);
    check("fe_no_rise", rise_cnt - rise0, 0);
    idle(100);

    // 10-cycle glitch: busy for 9 ticks (36 cycles) then rejected
    fe0 = fe_cnt; rise0 = rise_cnt;
    low(10);
    idle(100);
    @(negedge clk);
    check("glitch_busy_len", last_busy_len, 36);
    check("glitch_no_fe", fe_cnt - fe0, 0);
    check("glitch_no_rise", rise_cnt - rise0, 0);
    check("glitch_data_kept", int'(rx_data), 'hA5);

    // Back-to-back frames while the window is open: one overrun, window reloaded
    ov0 = ov_cnt; rise0 = rise_cnt;
    drive_frame(8'h11, 1'b1, -1, 0, -1, p);
    drive_frame(8'h22, 1'b1, -1, 0, -1, p2);
    idle(800);
    check("ovr_count", ov_cnt - ov0, 1);
    check("ovr_time", last_ov - p2, 615);
    check("ovr_status_continuous", rise_cnt - rise0, 1);
    check("ovr_data", int'(rx_data), 'h22);
    check("ovr_hold_reload", last_fall - last_ov, 700);

    // One-tick flip covering only sample 8 of data bit 3 of 0x00
    drive_frame(8'h00, 1'b1, 286, 4, -1, p);
    idle(800);
    check("noise_latency", last_rise - p, 615);
    check("noise_data", int'(data_at_rise), 'h00);

    // Reset during data bit 5 while a previous byte is still valid
    drive_frame(8'hC3, 1'b1, -1, 0, -1, p);
    drive_frame(8'h77, 1'b1, -1, 0, 6 * BIT_CYC + 32, p2);
    @(negedge clk);
    check("rst_outputs_zero", int'({rx_data, rx_status, frame_err, overrun, busy}), 0);
    idle(100);
    drive_frame(8'h5A, 1'b1, -1, 0, -1, p);
    idle(800);
    check("rst_next_latency", last_rise - p, 615);
    check("rst_next_data", int'(data_at_rise), 'h5A);

    // Random frames: bad stop bits, noise bursts, resets, glitches, variable gaps
    for (int i = 0; i < 25; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) begin
        fa = int'($urandom_range(0, 639));
        fl = int'($urandom_range(1, 6));
      end else begin
        fa = -1;
        fl = 0;
      end
      ra = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 639)) : -1;
      drive_frame(d, stop, fa, fl, ra, p);
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 900));
      if (gap > 0) idle(gap);
      if ($urandom_range(0, 4) == 0) begin
        low(int'($urandom_range(1, 40)));
        idle(100);
      end
    end
    idle(800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
